// File: rtl/rr_arbiter_83.sv
// rr_arbiter_83: eight-way round-robin arbiter with a per-owner hold limit.
// Requester n drives req[7-n]; the grant is returned one-hot (same order) and as index n.
module rr_arbiter_83 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [7:0] MH = 8'(MAX_HOLD);
    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;
    logic [7:0] r;
    logic [7:0] masked;
    logic [2:0] win;
    logic       any;
    logic       owner_req;
    logic       take;
    assign r = {<<{req}};
    assign owner_req = (state == GRANT) && r[gnt_idx];
    // The owner never competes: either it released, or it is being rotated away.
    always_comb begin
        masked = r & ~((state == GRANT) ? (8'd1 << gnt_idx) : 8'd0);
        any = |masked;
        win = ptr;
        for (int i = 7; i >= 0; i--)
            if (masked[ptr + 3'(i)]) win = ptr + 3'(i);
        take = any && (!owner_req || hold_cnt >= MH);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (take) begin
            state     <= GRANT;
            gnt       <= 8'h80 >> win;
            gnt_idx   <= win;
            gnt_valid <= 1'b1;
            hold_cnt  <= 8'd1;
            ptr       <= win + 3'd1;
        end else if (owner_req) begin
            hold_cnt <= (hold_cnt < MH) ? hold_cnt + 8'd1 : 8'd1;
        end else if (state == GRANT) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_83.sv
// tb_rr_arbiter_83: scoreboard bench for two arbiters (MAX_HOLD=4 and MAX_HOLD=1) sharing one req bus.
// Expected outputs come from a queue filled by the stimulus process using a rule-level model.
module tb_rr_arbiter_83;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt4, gnt1;
    logic [2:0] idx4, idx1;
    logic       v4, v1;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass = 0;

    bit m_valid[2];
    int m_owner[2];
    int m_ptr[2];
    int m_held[2];

    always #5 clk = ~clk;

    rr_arbiter_83 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(v4)
    );
    rr_arbiter_83 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(v1)
    );

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s at %0t: got gnt=%h idx=%0d valid=%b, want gnt=%h idx=%0d valid=%b",
                      nm, $time, act[11:4], act[3:1], act[0], expv[11:4], expv[3:1], expv[0]);
    endtask

    // First requesting index found scanning start, start+1, ... (mod 8), skipping excl.
    function automatic int pick(input logic [7:0] rq, input int start, input int excl);
        for (int j = 0; j < 8; j++) begin
            int n = (start + j) % 8;
            if (n != excl && rq[7-n]) return n;
        end
        return -1;
    endfunction

    task automatic grant_to(input int k, input int w);
        m_valid[k] = 1'b1;
        m_owner[k] = w;
        m_held[k]  = 1;
        m_ptr[k]   = (w + 1) % 8;
    endtask

    task automatic model_step(input int k, input logic [7:0] rq, input bit rs);
        int mh = (k == 0) ? 4 : 1;
        int w;
        if (rs) begin
            m_valid[k] = 1'b0; m_owner[k] = 0; m_ptr[k] = 0; m_held[k] = 0;
        end else if (!m_valid[k]) begin
            w = pick(rq, m_ptr[k], -1);
            if (w >= 0) grant_to(k, w);
        end else if (!rq[7-m_owner[k]]) begin
            w = pick(rq, m_ptr[k], m_owner[k]);
            if (w >= 0) grant_to(k, w);
            else begin m_valid[k] = 1'b0; m_owner[k] = 0; m_held[k] = 0; end
        end else if (m_held[k] < mh) begin
            m_held[k]++;
        end else begin
            w = pick(rq, m_owner[k] + 1, m_owner[k]);
            if (w >= 0) grant_to(k, w);
            else m_held[k] = 1;
        end
    endtask

    function automatic logic [11:0] expected(input int k);
        logic [7:0] g = m_valid[k] ? (8'h80 >> m_owner[k]) : 8'h00;
        logic [2:0] i = m_valid[k] ? 3'(m_owner[k]) : 3'd0;
        return {g, i, m_valid[k]};
    endfunction

    // One clock of stimulus: drive on the falling edge, predict what the next rising edge yields.
    task automatic cyc(input logic [7:0] rq, input bit rs);
        exp_t e;
        @(negedge clk);
        req = rq;
        if (rs && !rst) begin
            rst = 1'b1;
            #1;
            check("async_reset_h4", {gnt4, idx4, v4}, 12'h000);
            check("async_reset_h1", {gnt1, idx1, v1}, 12'h000);
        end else begin
            rst = rs;
        end
        model_step(0, rq, rs);
        model_step(1, rq, rs);
        e.a = expected(0);
        e.b = expected(1);
        q.push_back(e);
    endtask

    task automatic hold(input logic [7:0] rq, input int n);
        for (int i = 0; i < n; i++) cyc(rq, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("grant_h4", {gnt4, idx4, v4}, e.a);
                check("grant_h1", {gnt1, idx1, v1}, e.b);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] rq;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_owner[k] = 0; m_ptr[k] = 0; m_held[k] = 0;
        end
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b1);
        hold(8'h04, 10);
        hold(8'h00, 2);
        hold(8'hFF, 40);
        cyc(8'hFF, 1'b1);
        cyc(8'hFF, 1'b1);
        hold(8'hFF, 6);
        cyc(8'h00, 1'b1);
        cyc(8'h20, 1'b0);
        hold(8'hA4, 2);
        hold(8'h84, 2);
        hold(8'h80, 2);
        hold(8'h00, 2);
        cyc(8'h02, 1'b0);
        cyc(8'h00, 1'b0);
        hold(8'h82, 3);
        hold(8'h00, 1);
        hold(8'h18, 10);
        hold(8'h00, 1);
        rq = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0)
                rq = ($urandom_range(1) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            cyc(rq, $urandom_range(59) == 0);
        end
        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_83.md
# rr_arbiter_83

Eight-requester round-robin arbiter that shares one downstream resource between eight clients. It delivers the grant as a registered one-hot vector and as a 3-bit encoded index. The index uses the 8-to-3 encoder mapping: bit 7 maps to index 000 and bit 0 maps to index 111. It sits in front of the shared datapath and bounds how long any single client can hold it.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles one owner keeps the grant while others are waiting. Legal range 1..255.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  [7:0]  request lines; requester n drives req[7-n]. Level-sensitive; a requester holds the line for as long as it wants the resource.
- gnt  output [7:0]  registered one-hot grant, same bit order as req. At most one bit is set.
- gnt_idx  output [2:0]  registered index n of the current owner.
- gnt_valid  output 1  registered; high while any grant is active.

## Operation
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - ptr[2:0]: priority pointer holding the index searched first.
  - hold_cnt[7:0]: number of cycles the current owner has held the grant.
  - owner[2:0]: equal to gnt_idx.
- Winner search:
  - Scan indices ptr, ptr+1, … ptr+7, all modulo 8, and take the first with an active request.
  - The search excludes the current owner when forced rotation applies.
- IDLE:
  - gnt=0, gnt_idx=000, gnt_valid=0.
  - If any req bit is high, grant the winner and go to GRANT.
- GRANT, evaluated each rising edge:
  - Owner's req low:
    - If another request is pending, grant the next winner directly, with no idle cycle between grants.
    - Otherwise go to IDLE.
  - Owner's req high and hold_cnt < MAX_HOLD: keep the grant; hold_cnt increments.
  - Owner's req high, hold_cnt == MAX_HOLD, and another request pending: forced rotation to the next winner, searching from owner+1.
  - Owner's req high, hold_cnt == MAX_HOLD, and no other request: keep the grant and reload hold_cnt to 1.
- On every new grant, including re-grant after IDLE:
  - hold_cnt <= 1.
  - ptr <= winner+1 modulo 8 (index 7 wraps to 0).
  - gnt, gnt_idx and gnt_valid update together on the same edge.
- Encoding rules:
  - gnt == (8'b1000_0000 >> gnt_idx) whenever gnt_valid is high.
  - gnt_idx is 000 whenever gnt_valid is low.
- Fairness: with all eight requesting continuously, each requester is granted exactly once every 8 grant periods.
- Reset (rst high, at any time including mid-grant):
  - Immediately, without waiting for clk: gnt=0, gnt_idx=000, gnt_valid=0, ptr=0, hold_cnt=0, state IDLE.
  - After rst falls, the first arbitration happens on the next rising edge.

## Timing
- Grant latency:
  - req sampled at edge k; gnt visible after edge k.
  - An idle requester sees its grant one cycle after asserting req.
- Release latency: the owner drops req before edge k; the new grant, or the return to IDLE, is visible after edge k.
- Hold limit:
  - An owner that keeps req high under contention holds gnt for exactly MAX_HOLD cycles.
  - With MAX_HOLD=1 the grant rotates every cycle.
- Simultaneous owner release and new requests on the same edge: resolved by the single round-robin search; no bubble cycle.
- Requests that arrive and drop between two edges are never seen and never granted.
- Outputs are glitch-free; no combinational path from req to gnt.

## Test plan
- Reset: assert rst mid-GRANT with req=8'hFF -> gnt=00, gnt_idx=000, gnt_valid=0 immediately. After release, the first grant goes to index 0 (gnt=8'h80).
- Single requester: req=8'b0000_0100 held 10 cycles, MAX_HOLD=4 -> gnt=8'b0000_0100 and gnt_idx=101 for all 10 cycles (hold_cnt reloads, no drop). After req falls, gnt_valid=0 one cycle later.
- Full contention: req=8'hFF, MAX_HOLD=4 -> gnt_idx sequence 0,1,…,7 with each value held exactly 4 cycles, then back to 0 (wrap 7→0).
- Back-to-back release: owner index 2 drops req while indices 5 and 0 are requesting -> next cycle gnt_idx=101 with no IDLE cycle. When index 5 drops, gnt_idx=000.
- Pointer fairness: index 6 is granted and releases; then req=8'b1000_0010 (indices 0 and 6) -> index 0 wins because ptr=7 and the search wraps.
- MAX_HOLD=1 with indices 3 and 4 requesting -> gnt_idx alternates 3,4,3,4 every cycle. gnt always equals 8'h80>>gnt_idx.
